adc_sequencer: RTL and testbench
================================

ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameter PERIOD_CYC, default 50000, clock cycles between conversion triggers (minimum 2).
REQ-002 Parameter TIMEOUT_CYC, default 1000, maximum cycles to wait for adc_done after a trigger (minimum 2).
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 Port enable  input  1  level; 1 = run periodic acquisition, 0 = halt.
REQ-006 Port err_clr  input  1  one-cycle pulse; clears error flags.
REQ-007 Port adc_start  output  1  one-cycle conversion trigger to the ADC.
REQ-008 Port adc_done  input  1  one-cycle pulse; adc_data valid in the same cycle.
REQ-009 Port adc_data  input  8  raw ADC code.
REQ-010 Port code  output  8  averaged raw code, fed to the ADC-to-BCD transcoder.
REQ-011 Port code_valid  output  1  one-cycle strobe marking a new code value.
REQ-012 Port range_err  output  1  sticky flag; out-of-range sample seen.
REQ-013 Port timeout_err  output  1  sticky flag; conversion timed out.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT, START and CONV.
REQ-015 IDLE: leave for WAIT when enable=1; period counter, timeout counter, accumulator and sample count are held at 0.
REQ-016 WAIT: the period counter increments every cycle; when it reaches PERIOD_CYC-1, clear it and go to START.
REQ-017 START: adc_start=1 for exactly this one cycle; clear the timeout counter; go to CONV.
REQ-018 CONV, adc_done=1 with adc_data in 0x38..0x9B inclusive: add the sample to the 10-bit accumulator, increment the 2-bit sample count, go to WAIT.
REQ-019 CONV, adc_done=1 with adc_data outside 0x38..0x9B: discard the sample, set range_err, go to WAIT.
REQ-020 CONV, no adc_done by the time the timeout counter reaches TIMEOUT_CYC-1: set timeout_err, discard the sample, go to WAIT; adc_done in that same final cycle counts as done, not as a timeout.
REQ-021 When the 4th valid sample is accepted:
- register code = (accumulator + sample) >> 2, truncated;
- assert code_valid for exactly the next cycle, with code updated in that cycle;
- clear the accumulator and sample count.
REQ-022 code SHALL hold its value until the next publish, including while in IDLE.
REQ-023 adc_done SHALL be ignored outside CONV.
REQ-024 enable=0 in any state: go to IDLE on the next edge, discard any partial accumulation, do not assert code_valid; adc_start SHALL NOT be asserted in that cycle or later.
REQ-025 err_clr=1 clears both flags; a new error event in the same cycle takes priority and leaves its flag at 1.
REQ-026 After every trigger, the next adc_start SHALL occur exactly PERIOD_CYC cycles after leaving CONV.

Reset
REQ-027 On rst_n=0, asynchronously and without waiting for a clock edge, set:
- state = IDLE;
- adc_start=0, code_valid=0, range_err=0, timeout_err=0;
- code = 8'h38;
- all counters and the accumulator = 0.
REQ-028 Reset asserted mid-conversion SHALL abandon that conversion; after release, a late adc_done SHALL be ignored.

Structure
REQ-029 Shared package adc_seq_pkg SHALL hold:
- ADC_CODE_MIN = 8'h38 and ADC_CODE_MAX = 8'h9B;
- AVG_SAMPLES = 4;
- the FSM state enumeration.
REQ-030 A single sub-module adc_seq_timer SHALL implement the clearable up-counter with terminal-count compare, instantiated twice (period and timeout).

Verification
REQ-031 Assert rst_n=0 mid-CONV -> all outputs 0 except code=0x38; after release, adc_start first occurs PERIOD_CYC cycles after enable=1.
REQ-032 With PERIOD_CYC=8, four conversions returning 0x40, 0x41, 0x42, 0x43 -> code=0x41 and a single code_valid pulse one cycle after the 4th adc_done.
REQ-033 Samples 0x40, 0x20, 0x40, 0x40, 0x40 -> range_err=1 after the 2nd sample; code=0x40 is published after the 5th sample.
REQ-034 With TIMEOUT_CYC=5 and no adc_done -> timeout_err=1 on cycle 5 of CONV, return to WAIT, next adc_start 8 cycles later.
REQ-035 Drop enable after 2 valid samples, then re-enable -> no code_valid until 4 fresh samples; code retains its previous value meanwhile.
REQ-036 err_clr in the same cycle as an out-of-range adc_done -> range_err remains 1; a later lone err_clr -> range_err=0.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared constants, FSM state encoding and helpers for the ADC sequencer.
package adc_seq_pkg;

   // Valid window for raw ADC codes (inclusive on both ends).
   localparam logic [7:0] ADC_CODE_MIN = 8'h38;
   localparam logic [7:0] ADC_CODE_MAX = 8'h9B;

   // Number of accepted samples averaged into one published code.
   localparam int AVG_SAMPLES = 4;
   localparam int AVG_SHIFT   = $clog2(AVG_SAMPLES);
   localparam int CNT_W       = $clog2(AVG_SAMPLES);

   // Accumulator wide enough for AVG_SAMPLES full-scale 8-bit samples.
   localparam int ACC_W = 8 + AVG_SHIFT;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_START = 2'd2,
      ST_CONV  = 2'd3
   } state_t;

   // True when a raw code lies inside the accepted window.
   function automatic logic in_code_range(input logic [7:0] d);
      return (d >= ADC_CODE_MIN) && (d <= ADC_CODE_MAX);
   endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// Clearable up-counter with a terminal-count flag at TC-1.
// clr has priority over inc; the count holds when neither is asserted.
module adc_seq_timer #(
   parameter int TC = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic at_tc
);

   localparam int W = (TC > 1) ? $clog2(TC) : 1;
   localparam logic [W-1:0] LAST = W'(TC - 1);

   logic [W-1:0] count;

   // Counter register: clear wins, otherwise count up on inc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign at_tc = (count == LAST);

endmodule

// File: rtl/adc_sequencer.sv
// Periodic ADC acquisition: triggers a conversion every PERIOD_CYC cycles,
// guards each conversion with a timeout, range-checks samples and publishes
// the average of every AVG_SAMPLES accepted samples on code/code_valid.
//
// Handshake: adc_start is a one-cycle request; the ADC answers with a
// one-cycle adc_done carrying adc_data in that same cycle. adc_done is only
// looked at in CONV. code_valid is a one-cycle strobe with no back-pressure;
// code is stable from that strobe until the next one.
module adc_sequencer
   import adc_seq_pkg::*;
#(
   parameter int PERIOD_CYC  = 50000,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       err_clr,
   output logic       adc_start,
   input  logic       adc_done,
   input  logic [7:0] adc_data,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       range_err,
   output logic       timeout_err,
   output state_t     fsm_state
);

   state_t state;
   state_t next_state;

   logic period_clr;
   logic period_inc;
   logic period_tc;
   logic tmo_clr;
   logic tmo_inc;
   logic tmo_tc;

   logic accept;
   logic reject;
   logic timeout;

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] sum;

   adc_seq_timer #(.TC(PERIOD_CYC)) u_period (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (period_clr),
      .inc   (period_inc),
      .at_tc (period_tc)
   );

   adc_seq_timer #(.TC(TIMEOUT_CYC)) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmo_clr),
      .inc   (tmo_inc),
      .at_tc (tmo_tc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control decode. A low enable overrides everything so no
   // trigger, sample or error event is produced on the way back to IDLE.
   always_comb begin
      next_state = state;
      adc_start  = 1'b0;
      accept     = 1'b0;
      reject     = 1'b0;
      timeout    = 1'b0;
      period_clr = 1'b0;
      period_inc = 1'b0;
      tmo_clr    = 1'b0;
      tmo_inc    = 1'b0;
      if (!enable) begin
         next_state = ST_IDLE;
         period_clr = 1'b1;
         tmo_clr    = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               period_clr = 1'b1;
               tmo_clr    = 1'b1;
               next_state = ST_WAIT;
            end
            ST_WAIT: begin
               if (period_tc) begin
                  period_clr = 1'b1;
                  next_state = ST_START;
               end else begin
                  period_inc = 1'b1;
               end
            end
            ST_START: begin
               adc_start  = 1'b1;
               tmo_clr    = 1'b1;
               next_state = ST_CONV;
            end
            ST_CONV: begin
               // A done in the final timeout cycle still counts as done.
               if (adc_done) begin
                  if (in_code_range(adc_data)) begin
                     accept = 1'b1;
                  end else begin
                     reject = 1'b1;
                  end
                  tmo_clr    = 1'b1;
                  next_state = ST_WAIT;
               end else if (tmo_tc) begin
                  timeout    = 1'b1;
                  tmo_clr    = 1'b1;
                  next_state = ST_WAIT;
               end else begin
                  tmo_inc = 1'b1;
               end
            end
            default: begin
               next_state = ST_IDLE;
            end
         endcase
      end
   end

   assign sum = acc + {{(ACC_W-8){1'b0}}, adc_data};

   // Accumulate accepted samples and publish the truncated average.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         cnt        <= '0;
         code       <= ADC_CODE_MIN;
         code_valid <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         if (!enable || (state == ST_IDLE)) begin
            acc <= '0;
            cnt <= '0;
         end else if (accept) begin
            if (cnt == CNT_W'(AVG_SAMPLES - 1)) begin
               code       <= 8'(sum >> AVG_SHIFT);
               code_valid <= 1'b1;
               acc        <= '0;
               cnt        <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // Sticky error flags; a new event beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         range_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (reject) begin
            range_err <= 1'b1;
         end else if (err_clr) begin
            range_err <= 1'b0;
         end
         if (timeout) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer with PERIOD_CYC=8, TIMEOUT_CYC=5.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_adc_sequencer;
   import adc_seq_pkg::*;

   localparam int P = 8;
   localparam int T = 5;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       err_clr;
   logic       adc_start;
   logic       adc_done;
   logic [7:0] adc_data;
   logic [7:0] code;
   logic       code_valid;
   logic       range_err;
   logic       timeout_err;
   state_t     fsm_state;

   int total;
   int bad;
   int cv_cnt;

   adc_sequencer #(.PERIOD_CYC(P), .TIMEOUT_CYC(T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .err_clr     (err_clr),
      .adc_start   (adc_start),
      .adc_done    (adc_done),
      .adc_data    (adc_data),
      .code        (code),
      .code_valid  (code_valid),
      .range_err   (range_err),
      .timeout_err (timeout_err),
      .fsm_state   (fsm_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count code_valid pulses mid-cycle.
   initial cv_cnt = 0;
   always @(negedge clk) if (code_valid) cv_cnt++;

   // Hard time limit.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step until adc_start is seen; compare the number of edges taken.
   task automatic wait_start(input string tag, input int exp);
      int n;
      n = 0;
      while (adc_start !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      check(tag, 16'(n), 16'(exp));
   endtask

   // Called in the START cycle: answer in the first CONV cycle.
   task automatic conv(input logic [7:0] d, input logic clr);
      step();
      adc_done = 1'b1;
      adc_data = d;
      err_clr  = clr;
      step();
      adc_done = 1'b0;
      err_clr  = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      enable   = 1'b0;
      err_clr  = 1'b0;
      adc_done = 1'b0;
      adc_data = 8'h00;
      repeat (3) step();
      check("rst_code", 16'(code), 16'h0038);
      check("rst_start", 16'(adc_start), 16'h0000);
      check("rst_cv", 16'(code_valid), 16'h0000);
      check("rst_rerr", 16'(range_err), 16'h0000);
      check("rst_terr", 16'(timeout_err), 16'h0000);
      check("rst_state", 16'(fsm_state), 16'(ST_IDLE));
      rst_n = 1'b1;
      step();
      check("idle_hold", 16'(fsm_state), 16'(ST_IDLE));

      // Averaging of 0x40..0x43 -> 0x41
      enable = 1'b1;
      step();
      check("en_state", 16'(fsm_state), 16'(ST_WAIT));
      wait_start("first_start", P);
      conv(8'h40, 1'b0);
      check("avg_cv1", 16'(code_valid), 16'h0000);
      wait_start("period_1", P);
      conv(8'h41, 1'b0);
      wait_start("period_2", P);
      conv(8'h42, 1'b0);
      wait_start("period_3", P);
      conv(8'h43, 1'b0);
      check("avg_cv", 16'(code_valid), 16'h0001);
      check("avg_code", 16'(code), 16'h0041);
      wait_start("period_pub", P);
      check("avg_pulses", 16'(cv_cnt), 16'd1);

      // Out-of-range second sample
      conv(8'h40, 1'b0);
      check("rerr_1st", 16'(range_err), 16'h0000);
      wait_start("period_b1", P);
      conv(8'h20, 1'b0);
      check("rerr_2nd", 16'(range_err), 16'h0001);
      wait_start("period_b2", P);
      conv(8'h40, 1'b0);
      wait_start("period_b3", P);
      conv(8'h40, 1'b0);
      check("code_hold", 16'(code), 16'h0041);
      wait_start("period_b4", P);
      conv(8'h40, 1'b0);
      check("pub5_cv", 16'(code_valid), 16'h0001);
      check("pub5_code", 16'(code), 16'h0040);
      wait_start("period_b5", P);
      check("b_pulses", 16'(cv_cnt), 16'd2);

      // Clear collides with a new range error, then a lone clear
      conv(8'h9C, 1'b1);
      check("rerr_clr_same", 16'(range_err), 16'h0001);
      pulse_clr();
      check("rerr_lone_clr", 16'(range_err), 16'h0000);
      wait_start("period_c", P - 1);

      // Window boundaries are accepted: (0x38+0x9B)*2/4 = 0x69
      conv(8'h38, 1'b0);
      wait_start("period_d1", P);
      conv(8'h9B, 1'b0);
      wait_start("period_d2", P);
      conv(8'h38, 1'b0);
      wait_start("period_d3", P);
      conv(8'h9B, 1'b0);
      check("bnd_code", 16'(code), 16'h0069);
      check("bnd_rerr", 16'(range_err), 16'h0000);
      wait_start("period_d4", P);
      conv(8'h37, 1'b0);
      check("below_min", 16'(range_err), 16'h0001);
      pulse_clr();
      check("below_min_clr", 16'(range_err), 16'h0000);
      wait_start("period_d5", P - 1);

      // Timeout: no done for T cycles of CONV
      repeat (T) step();
      check("tmo_pre", 16'(timeout_err), 16'h0000);
      step();
      check("tmo_set", 16'(timeout_err), 16'h0001);
      check("tmo_state", 16'(fsm_state), 16'(ST_WAIT));
      wait_start("tmo_period", P);
      pulse_clr();
      check("tmo_clr", 16'(timeout_err), 16'h0000);
      repeat (T - 1) step();
      adc_done = 1'b1;
      adc_data = 8'h50;
      step();
      adc_done = 1'b0;
      check("tmo_last_done", 16'(timeout_err), 16'h0000);
      check("tmo_last_state", 16'(fsm_state), 16'(ST_WAIT));

      // adc_done outside CONV is ignored
      adc_done = 1'b1;
      adc_data = 8'h20;
      step();
      adc_done = 1'b0;
      check("ign_rerr", 16'(range_err), 16'h0000);
      wait_start("period_e", P - 1);

      // enable drops in the START cycle: trigger suppressed
      enable = 1'b0;
      #1;
      check("start_gate", 16'(adc_start), 16'h0000);
      step();
      check("drop_state", 16'(fsm_state), 16'(ST_IDLE));
      repeat (3) step();
      enable = 1'b1;
      step();
      wait_start("reen_start", P);

      // Partial accumulation discarded on enable drop
      conv(8'h50, 1'b0);
      wait_start("period_f1", P);
      conv(8'h50, 1'b0);
      enable = 1'b0;
      step();
      check("part_drop_state", 16'(fsm_state), 16'(ST_IDLE));
      check("code_keep_idle", 16'(code), 16'h0069);
      repeat (4) step();
      enable = 1'b1;
      step();
      wait_start("reen_start2", P);
      conv(8'h60, 1'b0);
      wait_start("period_f2", P);
      conv(8'h62, 1'b0);
      wait_start("period_f3", P);
      conv(8'h64, 1'b0);
      check("fresh_no_pub", 16'(cv_cnt), 16'd3);
      check("fresh_code_keep", 16'(code), 16'h0069);
      wait_start("period_f4", P);
      conv(8'h66, 1'b0);
      check("fresh_cv", 16'(code_valid), 16'h0001);
      check("fresh_code", 16'(code), 16'h0063);

      // Reset mid-CONV
      wait_start("period_g1", P);
      conv(8'h20, 1'b0);
      wait_start("period_g2", P);
      step();
      check("g_pre_state", 16'(fsm_state), 16'(ST_CONV));
      rst_n = 1'b0;
      #1;
      check("mid_rst_code", 16'(code), 16'h0038);
      check("mid_rst_start", 16'(adc_start), 16'h0000);
      check("mid_rst_cv", 16'(code_valid), 16'h0000);
      check("mid_rst_rerr", 16'(range_err), 16'h0000);
      check("mid_rst_terr", 16'(timeout_err), 16'h0000);
      check("mid_rst_state", 16'(fsm_state), 16'(ST_IDLE));
      enable = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      adc_done = 1'b1;
      adc_data = 8'h20;
      step();
      adc_done = 1'b0;
      check("late_done_rerr", 16'(range_err), 16'h0000);
      check("late_done_state", 16'(fsm_state), 16'(ST_IDLE));
      enable = 1'b1;
      step();
      wait_start("post_rst_start", P);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
